multi_bit_hs_tx: RTL and testbench
==================================

MULTI_BIT_HS_TX -- requirements
Module: multi_bit_hs_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: source-side buffer entries, power of two, minimum 2.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: flop stages on ack_in, minimum 2.
REQ-004 SHALL have port clka, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port din, input, DATA_WIDTH: payload, sampled when valid_in=1.
REQ-007 SHALL have port valid_in, input, 1: single-cycle write strobe; back-to-back strobes are allowed.
REQ-008 SHALL have port ready_in, output, 1: buffer not full.
REQ-009 SHALL have port data_out, output, DATA_WIDTH: payload held stable for the whole handshake.
REQ-010 SHALL have port req_out, output, 1: four-phase request level toward the destination domain.
REQ-011 SHALL have port ack_in, input, 1: four-phase acknowledge, asynchronous to clka.
REQ-012 SHALL have port fill, output, $clog2(DEPTH)+1: number of buffered entries, excluding the entry in flight.
REQ-013 SHALL have port overflow, output, 1: sticky flag, set when a write is dropped.

Function
REQ-014 SHALL pass ack_in through SYNC_STAGES flops before any use; ack_s denotes the last stage.
REQ-015 SHALL write din into the FIFO at edge k when valid_in=1 and ready_in=1; fill increments at that edge.
REQ-016 SHALL drop the write when valid_in=1 and ready_in=0, leave FIFO contents unchanged, and set overflow at that edge.
REQ-017 SHALL deassert ready_in whenever fill==DEPTH; there is no write-through on the cycle of a pop.
REQ-018 SHALL use a three-state FSM: IDLE, REQ, REL.
REQ-019 SHALL, in IDLE with fill>0 and ack_s=0, pop the head into data_out, set req_out=1, and enter REQ at the same edge.
REQ-020 SHALL, in IDLE with ack_s=1 (stale acknowledge), remain in IDLE and not pop.
REQ-021 SHALL, in REQ, hold req_out=1 and data_out until ack_s=1, then clear req_out and enter REL.
REQ-022 SHALL, in REL, hold data_out until ack_s=0, then enter IDLE.
REQ-023 SHALL, on a simultaneous write and pop, leave fill unchanged and update both read and write pointers.
REQ-024 SHALL produce req_out high at edge k+1 for a write at edge k into an empty FIFO with the FSM idle.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH, using an extra MSB to distinguish full from empty.
REQ-026 SHALL keep data_out unchanged except on a pop edge.
REQ-027 SHALL keep payload order equal to write order, with no loss other than REQ-016 drops.
REQ-028 SHALL keep req_out glitch-free, driven directly from a flop.

Reset
REQ-029 SHALL, at any edge with rst_n=0, apply: FSM=IDLE, req_out=0, data_out=0, fill=0, ready_in=1, overflow=0, pointers=0, synchronizer flops=0.
REQ-030 SHALL, on reset mid-handshake, discard buffered and in-flight data.
REQ-031 SHALL, after a mid-handshake reset, not start a new request until ack_s has been observed 0.
REQ-032 SHALL clear overflow only by reset.

Verification
REQ-033 Single transfer: write 0x01 with ack_in responding 3 cycles after req_out rises -> req_out=1 at k+1 with data_out=0x01; req_out falls 2+3 cycles later; FSM back to IDLE after ack_in falls.
REQ-034 Burst: writes 0x01..0x04 on consecutive edges with ack_in held 0 -> first pops immediately; fill reaches 3; ready_in stays 1; all four delivered in order once ack_in toggles.
REQ-035 Overflow: DEPTH=4, ack_in stuck 0, write 6 bytes 0x10..0x15 -> 0x10 in flight; 0x11..0x14 buffered; 0x15 dropped; overflow=1; ready_in=0.
REQ-036 Full plus pop: with fill=4, a pop coinciding with valid_in=1 -> write dropped per REQ-017; fill=3 next cycle.
REQ-037 Reset mid-REQ: rst_n=0 for 1 cycle while req_out=1 and ack_in=1 -> all outputs at reset values; no new req_out until ack_in low for SYNC_STAGES cycles.
REQ-038 Stale ack: ack_in=1 at startup with a buffered write -> no pop and req_out=0 until ack_s=0.

Source files
------------

// File: rtl/multi_bit_hs_tx.sv
// Source side of a four-phase multi-bit clock-domain handshake: a small FIFO
// feeds a request/acknowledge FSM that holds each payload stable until released.
module multi_bit_hs_tx #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clka,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    valid_in,
    output logic                    ready_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    req_out,
    input  logic                    ack_in,
    output logic [$clog2(DEPTH):0]  fill,
    output logic                    overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] prime_q, prime_d;
    logic [AW:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   req_q, req_d;
    logic                   ovf_q, ovf_d;
    state_t                 state_q, state_d;
    logic                   ack_s, wr_en, pop;

    assign ack_s    = sync_q[SYNC_STAGES-1];
    assign fill     = wptr_q - rptr_q;
    assign ready_in = (fill != FULL_CNT);
    assign data_out = data_q;
    assign req_out  = req_q;
    assign overflow = ovf_q;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], ack_in};
        // prime_q fills with ones once the real ack_in has reached ack_s after
        // reset, so the reset-zeroed synchronizer cannot fake a released ack.
        prime_d = {prime_q[SYNC_STAGES-2:0], 1'b1};
        wr_en   = valid_in && ready_in;
        pop     = (state_q == IDLE) && (fill != '0) && prime_q[SYNC_STAGES-1] && !ack_s;
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        rptr_d  = rptr_q;
        wptr_d  = wr_en ? (wptr_q + PTR_ONE) : wptr_q;
        ovf_d   = ovf_q | (valid_in & ~ready_in);
        case (state_q)
            IDLE: if (pop) begin
                data_d  = mem_q[rptr_q[AW-1:0]];
                rptr_d  = rptr_q + PTR_ONE;
                req_d   = 1'b1;
                state_d = REQ;
            end
            REQ: if (ack_s) begin
                req_d   = 1'b0;
                state_d = REL;
            end
            REL: if (!ack_s) state_d = IDLE;
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
            sync_q  <= '0;
            prime_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ovf_q   <= ovf_d;
            sync_q  <= sync_d;
            prime_q <= prime_d;
        end
    end

    always_ff @(posedge clka) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= din;
    end
endmodule

// File: tb/tb_multi_bit_hs_tx.sv
// Directed bench for multi_bit_hs_tx: inputs driven and outputs checked on the
// falling edge, with the acknowledge side played by hand.
module tb_multi_bit_hs_tx;
    logic       clka = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       valid_in;
    logic       ready_in;
    logic [7:0] data_out;
    logic       req_out;
    logic       ack_in;
    logic [2:0] fill;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    multi_bit_hs_tx #(.DATA_WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clka(clka), .rst_n(rst_n), .din(din), .valid_in(valid_in),
        .ready_in(ready_in), .data_out(data_out), .req_out(req_out),
        .ack_in(ack_in), .fill(fill), .overflow(overflow)
    );

    always #5 clka = ~clka;

    task automatic step();
        @(negedge clka);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input logic level, input string tag);
        for (int i = 0; i < 20 && req_out !== level; i++) step();
        chk(tag, {31'd0, req_out}, {31'd0, level});
    endtask

    task automatic hs(input logic [7:0] exp, input string tag);
        wait_req(1'b1, {tag, "_req"});
        chk({tag, "_data"}, {24'd0, data_out}, {24'd0, exp});
        ack_in = 1'b1;
        wait_req(1'b0, {tag, "_rel"});
        ack_in = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_fill [6];
        logic       exp_rdy  [6];
        logic       exp_ovf  [6];

        // Startup with a stale acknowledge
        rst_n = 1'b0; ack_in = 1'b1; valid_in = 1'b0; din = '0;
        repeat (3) step();
        chk("rst_req",   {31'd0, req_out},  32'd0);
        chk("rst_data",  {24'd0, data_out}, 32'd0);
        chk("rst_fill",  {29'd0, fill},     32'd0);
        chk("rst_ready", {31'd0, ready_in}, 32'd1);
        chk("rst_ovf",   {31'd0, overflow}, 32'd0);

        rst_n = 1'b1; din = 8'hA5; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        chk("stale_fill", {29'd0, fill}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stale_noreq", {31'd0, req_out}, 32'd0);
        end
        ack_in = 1'b0;
        step(); chk("stale_sync1", {31'd0, req_out}, 32'd0);
        step(); chk("stale_sync2", {31'd0, req_out}, 32'd0);
        step(); chk("stale_req",   {31'd0, req_out}, 32'd1);
        chk("stale_data", {24'd0, data_out}, 32'h A5);
        chk("stale_fill0", {29'd0, fill}, 32'd0);
        ack_in = 1'b1;
        wait_req(1'b0, "stale_rel");
        ack_in = 1'b0;
        repeat (4) step();

        // Single transfer with ack three cycles after the request
        din = 8'h01; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        chk("single_k_req",  {31'd0, req_out}, 32'd0);
        chk("single_k_fill", {29'd0, fill},    32'd1);
        step();
        chk("single_k1_req",  {31'd0, req_out},  32'd1);
        chk("single_k1_data", {24'd0, data_out}, 32'h01);
        chk("single_k1_fill", {29'd0, fill},     32'd0);
        step(); step();
        ack_in = 1'b1;
        step(); chk("single_r3_req", {31'd0, req_out}, 32'd1);
        step(); chk("single_r4_req", {31'd0, req_out}, 32'd1);
        step(); chk("single_r5_req", {31'd0, req_out}, 32'd0);
        chk("single_rel_data", {24'd0, data_out}, 32'h01);
        ack_in = 1'b0;
        step();
        chk("single_hold_data", {24'd0, data_out}, 32'h01);
        repeat (4) step();

        // Burst of four with ack held low
        exp_fill = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0};
        for (int i = 0; i < 4; i++) begin
            din = 8'(i + 1); valid_in = 1'b1;
            step();
            chk($sformatf("burst_fill%0d", i),  {29'd0, fill},     {29'd0, exp_fill[i]});
            chk($sformatf("burst_ready%0d", i), {31'd0, ready_in}, 32'd1);
        end
        valid_in = 1'b0;
        chk("burst_head", {24'd0, data_out}, 32'h01);
        hs(8'h01, "burst0");
        hs(8'h02, "burst1");
        hs(8'h03, "burst2");
        hs(8'h04, "burst3");
        chk("burst_empty", {29'd0, fill}, 32'd0);
        repeat (4) step();

        // Overflow with ack stuck low
        exp_fill = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        exp_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_ovf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            din = 8'(8'h10 + i); valid_in = 1'b1;
            step();
            chk($sformatf("ovf_fill%0d", i),  {29'd0, fill},     {29'd0, exp_fill[i]});
            chk($sformatf("ovf_ready%0d", i), {31'd0, ready_in}, {31'd0, exp_rdy[i]});
            chk($sformatf("ovf_flag%0d", i),  {31'd0, overflow}, {31'd0, exp_ovf[i]});
        end
        valid_in = 1'b0;
        chk("ovf_inflight", {24'd0, data_out}, 32'h10);
        chk("ovf_req",      {31'd0, req_out},  32'd1);

        // Full FIFO: the pop edge coincides with a write that must be dropped
        ack_in = 1'b1;
        wait_req(1'b0, "full_rel");
        chk("full_fill4", {29'd0, fill}, 32'd4);
        ack_in = 1'b0; din = 8'h77; valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (req_out) break;
        end
        valid_in = 1'b0;
        chk("full_pop_req",  {31'd0, req_out},  32'd1);
        chk("full_pop_data", {24'd0, data_out}, 32'h11);
        chk("full_pop_fill", {29'd0, fill},     32'd3);
        chk("full_pop_rdy",  {31'd0, ready_in}, 32'd1);
        chk("full_ovf_sticky", {31'd0, overflow}, 32'd1);
        hs(8'h11, "drain0");
        hs(8'h12, "drain1");
        hs(8'h13, "drain2");
        hs(8'h14, "drain3");
        chk("drain_empty", {29'd0, fill}, 32'd0);

        // Reset while a request is raised and ack is high
        for (int i = 0; i < 3; i++) begin
            din = 8'(8'h20 + i); valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
        repeat (5) step();
        chk("midrst_pre_req",  {31'd0, req_out},  32'd1);
        chk("midrst_pre_data", {24'd0, data_out}, 32'h20);
        chk("midrst_pre_fill", {29'd0, fill},     32'd2);
        ack_in = 1'b1; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_req",   {31'd0, req_out},  32'd0);
        chk("midrst_data",  {24'd0, data_out}, 32'd0);
        chk("midrst_fill",  {29'd0, fill},     32'd0);
        chk("midrst_ready", {31'd0, ready_in}, 32'd1);
        chk("midrst_ovf",   {31'd0, overflow}, 32'd0);
        din = 8'h5A; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        chk("midrst_wfill", {29'd0, fill}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_noreq", {31'd0, req_out}, 32'd0);
        end
        ack_in = 1'b0;
        step(); chk("midrst_sync1", {31'd0, req_out}, 32'd0);
        step(); chk("midrst_sync2", {31'd0, req_out}, 32'd0);
        step(); chk("midrst_newreq", {31'd0, req_out}, 32'd1);
        chk("midrst_newdata", {24'd0, data_out}, 32'h5A);
        ack_in = 1'b1;
        wait_req(1'b0, "midrst_rel");
        ack_in = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
